// File: rtl/rom_bus_arbiter.sv
// Shares the program ROM between fetch and data read ports.
// Data has priority; a starve counter guarantees fetch progress.
module rom_bus_arbiter #(
  parameter logic [15:0] ROM_BASE     = 16'hC000,
  parameter logic [16:0] ROM_SIZE     = 17'h4000,
  parameter int          STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [15:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic        d_bw,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic        d_err,
  output logic [15:0] rom_addr,
  output logic        rom_bw,
  input  logic [15:0] rom_in,
  output logic        busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  localparam logic [16:0] LO = {1'b0, ROM_BASE};
  localparam logic [16:0] HI = LO + ROM_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic          own_d_q;
  logic          bw_q;
  logic          ok_q;
  logic [15:0]   rom_addr_q;
  logic          rom_bw_q;
  logic [15:0]   rdata_q;
  logic          err_q;
  logic [CW-1:0] starve_q;

  logic          can_gnt;
  logic          if_pri;
  logic          gnt;
  logic [15:0]   g_addr;
  logic          g_bw;
  logic          g_ok;
  logic [15:0]   g_rom_addr;
  logic          resp;

  // rst_n gates grants so nothing is accepted while held in reset
  assign can_gnt = rst_n &&
                   (state_q == IDLE || state_q == RESP);
  assign if_pri  = if_req && (starve_q == LIM);
  assign d_gnt   = can_gnt && d_req && !if_pri;
  assign if_gnt  = can_gnt && if_req && !d_gnt;
  assign gnt     = d_gnt || if_gnt;

  assign g_addr = d_gnt ? d_addr : if_addr;
  assign g_bw   = d_gnt && d_bw;
  assign g_ok   = ({1'b0, g_addr} >= LO) &&
                  ({1'b0, g_addr} < HI);
  assign g_rom_addr = g_bw ? g_addr
                           : {g_addr[15:1], 1'b0};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = gnt ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      own_d_q    <= 1'b0;
      bw_q       <= 1'b0;
      ok_q       <= 1'b0;
      rom_addr_q <= 16'h0;
      rom_bw_q   <= 1'b0;
      rdata_q    <= 16'h0;
      err_q      <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        own_d_q <= d_gnt;
        bw_q    <= g_bw;
        ok_q    <= g_ok;
        // out-of-range accesses leave the ROM bus untouched
        if (g_ok) begin
          rom_addr_q <= g_rom_addr;
          rom_bw_q   <= g_bw;
        end
      end
      if (state_q == ACCESS) begin
        err_q <= !ok_q;
        if (!ok_q)     rdata_q <= 16'h0;
        else if (bw_q) rdata_q <= {8'h00, rom_in[7:0]};
        else           rdata_q <= rom_in;
      end
      if (if_gnt || !if_req)
        starve_q <= '0;
      else if (d_gnt && starve_q != LIM)
        starve_q <= starve_q + CW'(1);
    end
  end

  assign resp      = (state_q == RESP);
  assign d_rvalid  = resp && own_d_q;
  assign if_rvalid = resp && !own_d_q;
  assign d_rdata   = d_rvalid ? rdata_q : 16'h0;
  assign if_rdata  = if_rvalid ? rdata_q : 16'h0;
  assign d_err     = d_rvalid && err_q;
  assign if_err    = if_rvalid && err_q;
  assign rom_addr  = rom_addr_q;
  assign rom_bw    = rom_bw_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Directed bench for rom_bus_arbiter with a small ROM model.
// Checks latency, byte/word, range, starvation and reset abort.
module tb_rom_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [15:0] if_addr, if_rdata;
  logic        d_req, d_bw, d_gnt, d_rvalid, d_err;
  logic [15:0] d_addr, d_rdata;
  logic [15:0] rom_addr, rom_in;
  logic        rom_bw, busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rom_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_bw(d_bw),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .rom_addr(rom_addr), .rom_bw(rom_bw),
    .rom_in(rom_in), .busy(busy)
  );

  function automatic logic [15:0] word_at(input logic [15:0] a);
    logic [15:0] e;
    e = {a[15:1], 1'b0};
    if (e == 16'hC000) return 16'h1234;
    return {e[7:0] ^ 8'hA5, e[15:8]};
  endfunction

  // byte mode returns the addressed byte in the low lane
  always_comb begin
    rom_in = word_at(rom_addr);
    if (rom_bw)
      rom_in = {8'h00, rom_addr[0] ? rom_in[15:8] : rom_in[7:0]};
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic data_xfer(input logic [15:0] a,
                           input logic bw,
                           input logic [15:0] e_ra,
                           input logic e_rbw,
                           input logic [15:0] e_rd,
                           input logic e_err);
    @(negedge clk);
    d_req = 1'b1; d_addr = a; d_bw = bw;
    #1;
    chk("d_gnt", d_gnt, 1);
    chk("if_gnt_quiet", if_gnt, 0);
    @(negedge clk);
    d_req = 1'b0; d_addr = 16'h0; d_bw = 1'b0;
    #1;
    chk("d_busy_acc", busy, 1);
    chk("d_rom_addr", rom_addr, e_ra);
    chk("d_rom_bw", rom_bw, e_rbw);
    chk("d_rvalid_early", d_rvalid, 0);
    @(negedge clk);
    #1;
    chk("d_rvalid", d_rvalid, 1);
    chk("d_rdata", d_rdata, e_rd);
    chk("d_err", d_err, e_err);
    chk("if_rvalid_quiet", if_rvalid, 0);
    chk("if_rdata_quiet", if_rdata, 0);
    @(negedge clk);
    #1;
    chk("d_rvalid_end", d_rvalid, 0);
    chk("d_busy_end", busy, 0);
  endtask

  initial begin
    logic e_d, p_d;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 16'h0;
    d_req = 1'b0; d_addr = 16'h0; d_bw = 1'b0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_rom_addr", rom_addr, 16'h0);
    chk("rst_rom_bw", rom_bw, 0);
    chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'hC000;
    #1;
    chk("f_gnt", if_gnt, 1);
    chk("f_d_gnt", d_gnt, 0);
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("f_rom_addr", rom_addr, 16'hC000);
    chk("f_rom_bw", rom_bw, 0);
    chk("f_rvalid_early", if_rvalid, 0);
    @(negedge clk);
    #1;
    chk("f_rvalid", if_rvalid, 1);
    chk("f_rdata", if_rdata, 16'h1234);
    chk("f_err", if_err, 0);
    chk("f_d_quiet", {d_rvalid, d_err, d_rdata}, 0);

    data_xfer(16'hC001, 1'b1, 16'hC001, 1'b1, 16'h0012, 1'b0);
    data_xfer(16'hC001, 1'b0, 16'hC000, 1'b0, 16'h1234, 1'b0);
    data_xfer(16'hBFFF, 1'b0, 16'hC000, 1'b0, 16'h0000, 1'b1);
    data_xfer(16'h0000, 1'b1, 16'hC000, 1'b0, 16'h0000, 1'b1);
    data_xfer(16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 16'h005B, 1'b0);

    // both ports saturated
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'hC006;
    d_req = 1'b1; d_addr = 16'hC004; d_bw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (i % 2 == 0) begin
        e_d = ((i / 2) % 4) != 3;
        chk("arb_d_gnt", d_gnt, e_d);
        chk("arb_if_gnt", if_gnt, !e_d);
      end else begin
        chk("arb_idle", {d_gnt, if_gnt}, 0);
      end
      chk("arb_overlap", if_rvalid && d_rvalid, 0);
      if (i >= 2 && i % 2 == 0) begin
        p_d = (((i - 2) / 2) % 4) != 3;
        chk("arb_d_rv", d_rvalid, p_d);
        chk("arb_if_rv", if_rvalid, !p_d);
        chk("arb_rdata", p_d ? d_rdata : if_rdata,
            p_d ? 16'hA1C0 : 16'hA3C0);
      end else begin
        chk("arb_rv_gap", {d_rvalid, if_rvalid}, 0);
      end
      @(negedge clk);
    end
    if_req = 1'b0; d_req = 1'b0;
    #1;
    chk("arb_last_rv", {d_rvalid, if_rvalid}, 2'b10);
    chk("arb_last_rd", d_rdata, 16'hA1C0);
    @(negedge clk);
    #1;
    chk("arb_drain", busy, 0);

    // reset during ACCESS
    @(negedge clk);
    d_req = 1'b1; d_addr = 16'hC002; d_bw = 1'b0;
    #1;
    chk("ra_gnt", d_gnt, 1);
    @(negedge clk);
    #1;
    chk("ra_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("ra_busy0", busy, 0);
    chk("ra_rom_addr", rom_addr, 16'h0);
    chk("ra_rom_bw", rom_bw, 0);
    chk("ra_gnt0", {d_gnt, if_gnt}, 0);
    chk("ra_rv0", {d_rvalid, if_rvalid, d_err}, 0);
    @(negedge clk);
    d_req = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("ra_post1", {d_rvalid, if_rvalid}, 0);
    @(negedge clk);
    #1;
    chk("ra_post2", {d_rvalid, if_rvalid}, 0);
    data_xfer(16'hC002, 1'b0, 16'hC002, 1'b0, 16'hA7C0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
